// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seven_seg_pkg;

   localparam logic [3:0] BCD_OVF   = 4'b1111;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_OFF    = 4'b1111;
   localparam logic [3:0] AN_D0     = 4'b1110;
   localparam logic [3:0] AN_D1     = 4'b1101;
   localparam logic [3:0] AN_D2     = 4'b1011;
   localparam logic [3:0] AN_D3     = 4'b0111;

   typedef struct packed {
      logic [3:0][3:0] dig;
      logic [3:0]      dp;
   } frame_t;

   function automatic logic [3:0] anode_sel(input logic [1:0] i);
      logic [3:0] a;
      a = AN_OFF;
      unique case (i)
         2'd0: a = AN_D0;
         2'd1: a = AN_D1;
         2'd2: a = AN_D2;
         2'd3: a = AN_D3;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD to active-low seven-segment decoder.
// 4'b1111 shows a dash; other non-decimal codes are blank.
module bcd_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      unique case (code)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         BCD_OVF: seg = SEG_DASH;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed common-anode display driver with
// frame snapshot, leading-zero blanking and anti-ghost guard.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int GUARD    = 4
)(
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [3:0] BCD0,
   input  logic [3:0] BCD1,
   input  logic [3:0] BCD2,
   input  logic [3:0] BCD3,
   input  logic [3:0] Dp,
   input  logic       Blank_lz,
   output logic [3:0] An,
   output logic [6:0] Seg,
   output logic       Dp_n
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] GRD  = CW'(GUARD);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   frame_t        snap;
   logic          load;

   logic          wrap;
   logic          take;
   logic [3:0]    cur;
   logic [6:0]    dec;
   logic          z3, z2, z1;
   logic          blank;
   logic [3:0]    an_d;
   logic [6:0]    seg_d;
   logic          dp_d;

   assign wrap = (cnt == LAST);
   assign take = load || (wrap && idx == 2'd3);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt  <= '0;
         idx  <= 2'd0;
         snap <= '0;
         load <= 1'b1;
      end else begin
         cnt  <= wrap ? '0 : cnt + CW'(1);
         load <= 1'b0;
         if (wrap)
            idx <= idx + 2'd1;
         if (take) begin
            snap.dig <= {BCD3, BCD2, BCD1, BCD0};
            snap.dp  <= Dp;
         end
      end
   end

   assign cur = snap.dig[idx];

   bcd_to_seg u_dec (
      .code (cur),
      .seg  (dec)
   );

   // A digit is a leading zero only if it and every higher digit is 0.
   assign z3 = (snap.dig[3] == 4'd0);
   assign z2 = z3 && (snap.dig[2] == 4'd0);
   assign z1 = z2 && (snap.dig[1] == 4'd0);

   always_comb begin
      blank = 1'b0;
      unique case (idx)
         2'd0: blank = 1'b0;
         2'd1: blank = z1;
         2'd2: blank = z2;
         2'd3: blank = z3;
      endcase
      blank = blank && Blank_lz;
   end

   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (cnt >= GRD) begin
         an_d  = anode_sel(idx);
         seg_d = blank ? SEG_BLANK : dec;
         dp_d  = ~snap.dp[idx];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         An   <= AN_OFF;
         Seg  <= SEG_BLANK;
         Dp_n <= 1'b1;
      end else begin
         An   <= an_d;
         Seg  <= seg_d;
         Dp_n <= dp_d;
      end
   end

endmodule
